// File: rtl/gpio_bank_if.sv
// Register bus between the core and gpio_bank: single-cycle write and read strobes,
// read data returned registered one cycle later with a one-cycle rvalid pulse.
interface gpio_bank_if;
   logic [2:0]  addr;
   logic [31:0] wdata;
   logic        we;
   logic        re;
   logic [31:0] rdata;
   logic        rvalid;

   modport master (output addr, wdata, we, re, input  rdata, rvalid);
   modport slave  (input  addr, wdata, we, re, output rdata, rvalid);
endinterface

// File: rtl/gpio_bank.sv
// Memory-mapped GPIO bank: direction/output registers, synchronised inputs and
// sticky per-pin edge capture feeding one masked level interrupt.
module gpio_bank #(
   parameter int          WIDTH     = 8,
   parameter logic [31:0] RESET_OUT = 32'h0
) (
   input  logic             clk,
   input  logic             rst,
   gpio_bank_if.slave       bus,
   input  logic [WIDTH-1:0] pad_in,
   output logic [WIDTH-1:0] pad_out,
   output logic [WIDTH-1:0] pad_oe,
   output logic             irq
);

   typedef enum logic [2:0] {
      REG_DATA_OUT   = 3'd0,
      REG_DIR        = 3'd1,
      REG_DATA_IN    = 3'd2,
      REG_IRQ_EN     = 3'd3,
      REG_IRQ_RISE   = 3'd4,
      REG_IRQ_FALL   = 3'd5,
      REG_IRQ_STATUS = 3'd6,
      REG_RSVD       = 3'd7
   } reg_addr_e;

   logic [WIDTH-1:0] data_out_q,   data_out_d;
   logic [WIDTH-1:0] dir_q,        dir_d;
   logic [WIDTH-1:0] irq_en_q,     irq_en_d;
   logic [WIDTH-1:0] irq_rise_q,   irq_rise_d;
   logic [WIDTH-1:0] irq_fall_q,   irq_fall_d;
   logic [WIDTH-1:0] irq_status_q, irq_status_d;
   logic [WIDTH-1:0] s1_q, s2_q, prev_q;
   logic [31:0]      rdata_q, rdata_d;
   logic             rvalid_q;

   logic [WIDTH-1:0] wbits;
   logic [WIDTH-1:0] w1c;
   logic [WIDTH-1:0] rise_ev;
   logic [WIDTH-1:0] fall_ev;
   logic             unused_wdata;

   assign wbits        = bus.wdata[WIDTH-1:0];
   assign unused_wdata = ^bus.wdata;
   assign rise_ev      = s2_q & ~prev_q & irq_rise_q;
   assign fall_ev      = ~s2_q & prev_q & irq_fall_q;

   always_comb begin
      // NOTE: every next-state value gets a default first, so no path can infer a latch.
      data_out_d = data_out_q;
      dir_d      = dir_q;
      irq_en_d   = irq_en_q;
      irq_rise_d = irq_rise_q;
      irq_fall_d = irq_fall_q;
      w1c        = '0;
      if (bus.we) begin
         case (reg_addr_e'(bus.addr))
            REG_DATA_OUT:   data_out_d = wbits;
            REG_DIR:        dir_d      = wbits;
            REG_IRQ_EN:     irq_en_d   = wbits;
            REG_IRQ_RISE:   irq_rise_d = wbits;
            REG_IRQ_FALL:   irq_fall_d = wbits;
            REG_IRQ_STATUS: w1c        = wbits;
            default:        ;
         endcase
      end
      // An edge landing on the same edge as its W1C keeps the bit set.
      irq_status_d = (irq_status_q & ~w1c) | rise_ev | fall_ev;
   end

   // Read data is taken from the current registers, i.e. before any same-cycle write.
   always_comb begin
      rdata_d = rdata_q;
      if (bus.re) begin
         rdata_d = '0;
         case (reg_addr_e'(bus.addr))
            REG_DATA_OUT:   rdata_d[WIDTH-1:0] = data_out_q;
            REG_DIR:        rdata_d[WIDTH-1:0] = dir_q;
            REG_DATA_IN:    rdata_d[WIDTH-1:0] = s2_q;
            REG_IRQ_EN:     rdata_d[WIDTH-1:0] = irq_en_q;
            REG_IRQ_RISE:   rdata_d[WIDTH-1:0] = irq_rise_q;
            REG_IRQ_FALL:   rdata_d[WIDTH-1:0] = irq_fall_q;
            REG_IRQ_STATUS: rdata_d[WIDTH-1:0] = irq_status_q;
            default:        rdata_d = '0;
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_out_q   <= RESET_OUT[WIDTH-1:0];
         dir_q        <= '0;
         irq_en_q     <= '0;
         irq_rise_q   <= '0;
         irq_fall_q   <= '0;
         irq_status_q <= '0;
         s1_q         <= '0;
         s2_q         <= '0;
         prev_q       <= '0;
         rdata_q      <= '0;
         rvalid_q     <= 1'b0;
      end else begin
         data_out_q   <= data_out_d;
         dir_q        <= dir_d;
         irq_en_q     <= irq_en_d;
         irq_rise_q   <= irq_rise_d;
         irq_fall_q   <= irq_fall_d;
         irq_status_q <= irq_status_d;
         s1_q         <= pad_in;
         s2_q         <= s1_q;
         prev_q       <= s2_q;
         rdata_q      <= rdata_d;
         rvalid_q     <= bus.re;
      end
   end

   assign bus.rdata  = rdata_q;
   assign bus.rvalid = rvalid_q;
   assign pad_out    = data_out_q;
   assign pad_oe     = dir_q;
   assign irq        = |(irq_status_q & irq_en_q);

endmodule

// File: tb/tb_gpio_bank.sv
// Self-checking bench for gpio_bank: directed vector table, edge-capture sequences,
// a WIDTH=1/32 sweep, and a randomized run against a behavioural register model.
module tb_gpio_bank;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  pad8;
   logic [7:0]  pad_out8, pad_oe8;
   logic        irq8;
   logic [0:0]  pad1, pad_out1, pad_oe1;
   logic        irq1;
   logic [31:0] pad32, pad_out32, pad_oe32;
   logic        irq32;

   int n_vec = 0;
   int n_err = 0;

   gpio_bank_if bus8 ();
   gpio_bank_if bus1 ();
   gpio_bank_if bus32 ();

   gpio_bank #(.WIDTH(8), .RESET_OUT(32'h0000_00A5)) dut (
      .clk(clk), .rst(rst), .bus(bus8),
      .pad_in(pad8), .pad_out(pad_out8), .pad_oe(pad_oe8), .irq(irq8));

   gpio_bank #(.WIDTH(1), .RESET_OUT(32'hFFFF_FFFF)) dut1 (
      .clk(clk), .rst(rst), .bus(bus1),
      .pad_in(pad1), .pad_out(pad_out1), .pad_oe(pad_oe1), .irq(irq1));

   gpio_bank #(.WIDTH(32), .RESET_OUT(32'hDEAD_BEEF)) dut32 (
      .clk(clk), .rst(rst), .bus(bus32),
      .pad_in(pad32), .pad_out(pad_out32), .pad_oe(pad_oe32), .irq(irq32));

   always #5 clk = ~clk;

   // Behavioural model of the 8-bit bank: a register array plus the pad value as
   // it was sampled 1, 2 and 3 edges ago (index 1 is what software sees as DATA_IN).
   logic [31:0] m_reg  [8];
   logic [31:0] m_hist [3];
   logic [31:0] m_rdata;
   logic        m_rvalid;

   function automatic logic [31:0] m_events();
      return (m_hist[1] & ~m_hist[2] & m_reg[4]) | (~m_hist[1] & m_hist[2] & m_reg[5]);
   endfunction

   function automatic logic [31:0] m_read(input logic [2:0] a);
      if (a == 3'd2) return m_hist[1];
      return m_reg[a];
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) m_reg[i] <= (i == 0) ? 32'h0000_00A5 : 32'h0;
         for (int i = 0; i < 3; i++) m_hist[i] <= 32'h0;
         m_rdata  <= 32'h0;
         m_rvalid <= 1'b0;
      end else begin
         if (bus8.we && (bus8.addr inside {3'd0, 3'd1, 3'd3, 3'd4, 3'd5}))
            m_reg[bus8.addr] <= bus8.wdata & 32'hFF;
         m_reg[6] <= (m_reg[6] & ~((bus8.we && bus8.addr == 3'd6) ? (bus8.wdata & 32'hFF) : 32'h0))
                     | m_events();
         m_hist[0] <= {24'h0, pad8};
         m_hist[1] <= m_hist[0];
         m_hist[2] <= m_hist[1];
         m_rvalid  <= bus8.re;
         if (bus8.re) m_rdata <= m_read(bus8.addr);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic wr8(input logic [2:0] a, input logic [31:0] d);
      bus8.we = 1'b1; bus8.addr = a; bus8.wdata = d;
      @(negedge clk);
      bus8.we = 1'b0;
   endtask

   task automatic rd8(input string nm, input logic [2:0] a, input logic [31:0] e);
      bus8.re = 1'b1; bus8.addr = a;
      @(negedge clk);
      bus8.re = 1'b0;
      check({nm, "_rvalid"}, 32'(bus8.rvalid), 32'h1);
      check(nm, bus8.rdata, e);
   endtask

   task automatic wrs(input logic [2:0] a, input logic [31:0] d);
      bus1.we = 1'b1;  bus1.addr = a;  bus1.wdata = d;
      bus32.we = 1'b1; bus32.addr = a; bus32.wdata = d;
      @(negedge clk);
      bus1.we = 1'b0; bus32.we = 1'b0;
   endtask

   task automatic rds(input string nm, input logic [2:0] a, input logic [31:0] e1, input logic [31:0] e32);
      bus1.re = 1'b1;  bus1.addr = a;
      bus32.re = 1'b1; bus32.addr = a;
      @(negedge clk);
      bus1.re = 1'b0; bus32.re = 1'b0;
      check({nm, "_w1_rvalid"}, 32'(bus1.rvalid), 32'h1);
      check({nm, "_w1"}, bus1.rdata, e1);
      check({nm, "_w32_rvalid"}, 32'(bus32.rvalid), 32'h1);
      check({nm, "_w32"}, bus32.rdata, e32);
   endtask

   typedef struct {
      logic        we;
      logic        re;
      logic [2:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic [7:0]  exp_out;
      logic [7:0]  exp_oe;
   } vec_t;

   localparam int NV = 18;
   vec_t vt [NV];

   initial begin
      // Reset-state reads, register access, DATA_IN write ignored, reserved slot, same-cycle we/re.
      vt[0]  = '{1'b0, 1'b1, 3'd0, 32'h0,         32'h0000_00A5, 8'hA5, 8'h00};
      vt[1]  = '{1'b0, 1'b1, 3'd1, 32'h0,         32'h0,         8'hA5, 8'h00};
      vt[2]  = '{1'b0, 1'b1, 3'd2, 32'h0,         32'h0000_003C, 8'hA5, 8'h00};
      vt[3]  = '{1'b0, 1'b1, 3'd3, 32'h0,         32'h0,         8'hA5, 8'h00};
      vt[4]  = '{1'b0, 1'b1, 3'd4, 32'h0,         32'h0,         8'hA5, 8'h00};
      vt[5]  = '{1'b0, 1'b1, 3'd5, 32'h0,         32'h0,         8'hA5, 8'h00};
      vt[6]  = '{1'b0, 1'b1, 3'd6, 32'h0,         32'h0,         8'hA5, 8'h00};
      vt[7]  = '{1'b0, 1'b1, 3'd7, 32'h0,         32'h0,         8'hA5, 8'h00};
      vt[8]  = '{1'b1, 1'b0, 3'd1, 32'hFFFF_FF0F, 32'h0,         8'hA5, 8'h0F};
      vt[9]  = '{1'b0, 1'b1, 3'd1, 32'h0,         32'h0000_000F, 8'hA5, 8'h0F};
      vt[10] = '{1'b1, 1'b0, 3'd2, 32'h0000_00FF, 32'h0,         8'hA5, 8'h0F};
      vt[11] = '{1'b0, 1'b1, 3'd2, 32'h0,         32'h0000_003C, 8'hA5, 8'h0F};
      vt[12] = '{1'b1, 1'b0, 3'd0, 32'h1234_5678, 32'h0,         8'h78, 8'h0F};
      vt[13] = '{1'b0, 1'b1, 3'd0, 32'h0,         32'h0000_0078, 8'h78, 8'h0F};
      vt[14] = '{1'b1, 1'b0, 3'd7, 32'hFFFF_FFFF, 32'h0,         8'h78, 8'h0F};
      vt[15] = '{1'b0, 1'b1, 3'd7, 32'h0,         32'h0,         8'h78, 8'h0F};
      vt[16] = '{1'b1, 1'b1, 3'd0, 32'h0000_00C3, 32'h0000_0078, 8'hC3, 8'h0F};
      vt[17] = '{1'b0, 1'b0, 3'd0, 32'h0,         32'h0,         8'hC3, 8'h0F};

      rst = 1'b1;
      pad8 = 8'h3C; pad1 = 1'b0; pad32 = 32'h0;
      bus8.we = 1'b0;  bus8.re = 1'b0;  bus8.addr = 3'd0;  bus8.wdata = 32'h0;
      bus1.we = 1'b0;  bus1.re = 1'b0;  bus1.addr = 3'd0;  bus1.wdata = 32'h0;
      bus32.we = 1'b0; bus32.re = 1'b0; bus32.addr = 3'd0; bus32.wdata = 32'h0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Read captured at an edge, then reset lands before its rvalid cycle ends.
      bus8.re = 1'b1; bus8.addr = 3'd1;
      @(posedge clk);
      #1;
      rst = 1'b1;
      bus8.re = 1'b0;
      @(negedge clk);
      check("rst_pad_out", 32'(pad_out8), 32'h0000_00A5);
      check("rst_pad_oe", 32'(pad_oe8), 32'h0);
      check("rst_irq", 32'(irq8), 32'h0);
      check("rst_rvalid", 32'(bus8.rvalid), 32'h0);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("post_rst_no_rvalid", 32'(bus8.rvalid), 32'h0);
      end

      for (int i = 0; i < NV; i++) begin
         bus8.we = vt[i].we; bus8.re = vt[i].re;
         bus8.addr = vt[i].addr; bus8.wdata = vt[i].wdata;
         @(negedge clk);
         bus8.we = 1'b0; bus8.re = 1'b0;
         check($sformatf("vec%0d_rvalid", i), 32'(bus8.rvalid), 32'(vt[i].re));
         if (vt[i].re) check($sformatf("vec%0d_rdata", i), bus8.rdata, vt[i].exp_rdata);
         check($sformatf("vec%0d_pad_out", i), 32'(pad_out8), 32'(vt[i].exp_out));
         check($sformatf("vec%0d_pad_oe", i), 32'(pad_oe8), 32'(vt[i].exp_oe));
      end

      // Rising capture on pin 0 with its two-edge synchroniser latency, then W1C.
      wr8(3'd4, 32'h01);
      wr8(3'd3, 32'h01);
      pad8 = 8'h3D;
      @(negedge clk); check("rise_irq_k",  32'(irq8), 32'h0);
      @(negedge clk); check("rise_irq_k1", 32'(irq8), 32'h0);
      @(negedge clk); check("rise_irq_k2", 32'(irq8), 32'h1);
      rd8("rise_status", 3'd6, 32'h01);
      wr8(3'd6, 32'h01);
      check("rise_w1c_irq", 32'(irq8), 32'h0);

      // Falling capture on pin 7 while masked, then unmask.
      wr8(3'd5, 32'h80);
      wr8(3'd3, 32'h00);
      pad8 = 8'hBD;
      repeat (4) @(negedge clk);
      pad8 = 8'h3D;
      repeat (4) @(negedge clk);
      check("fall_masked_irq", 32'(irq8), 32'h0);
      rd8("fall_status", 3'd6, 32'h80);
      wr8(3'd3, 32'h80);
      check("fall_unmask_irq", 32'(irq8), 32'h1);

      // Edge on pin 2 arriving at the same edge as its W1C: the set wins.
      wr8(3'd6, 32'hFF);
      wr8(3'd3, 32'h04);
      wr8(3'd4, 32'h04);
      check("simul_pre_irq", 32'(irq8), 32'h0);
      pad8 = 8'h39;
      repeat (4) @(negedge clk);
      pad8 = 8'h3D;
      @(negedge clk);
      @(negedge clk);
      wr8(3'd6, 32'h04);
      check("simul_irq", 32'(irq8), 32'h1);
      rd8("simul_status", 3'd6, 32'h04);
      check("simul_irq_hold", 32'(irq8), 32'h1);

      // Width sweep: WIDTH=1 and WIDTH=32 side by side.
      check("sw_rst_out_w1", 32'(pad_out1), 32'h1);
      check("sw_rst_out_w32", pad_out32, 32'hDEAD_BEEF);
      rds("sw_rst_data_out", 3'd0, 32'h1, 32'hDEAD_BEEF);
      rds("sw_rst_status", 3'd6, 32'h0, 32'h0);
      begin
         logic [2:0] rw_addr [5];
         rw_addr = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd5};
         for (int i = 0; i < 5; i++) begin
            wrs(rw_addr[i], 32'hFFFF_FFFF);
            rds($sformatf("sw_rw%0d", rw_addr[i]), rw_addr[i], 32'h1, 32'hFFFF_FFFF);
         end
      end
      check("sw_oe_w1", 32'(pad_oe1), 32'h1);
      check("sw_oe_w32", pad_oe32, 32'hFFFF_FFFF);
      wrs(3'd2, 32'hFFFF_FFFF);
      rds("sw_data_in", 3'd2, 32'h0, 32'h0);
      rds("sw_rsvd", 3'd7, 32'h0, 32'h0);
      check("sw_irq0_w1", 32'(irq1), 32'h0);
      check("sw_irq0_w32", 32'(irq32), 32'h0);
      pad1 = 1'b1; pad32 = 32'h1;
      repeat (3) @(negedge clk);
      check("sw_irq1_w1", 32'(irq1), 32'h1);
      check("sw_irq1_w32", 32'(irq32), 32'h1);
      rds("sw_status", 3'd6, 32'h1, 32'h1);
      wrs(3'd6, 32'hFFFF_FFFF);
      check("sw_clr_w1", 32'(irq1), 32'h0);
      check("sw_clr_w32", 32'(irq32), 32'h0);

      // Randomized traffic on the 8-bit bank against the model, with one async reset.
      for (int c = 0; c < 600; c++) begin
         check("rnd_pad_out", 32'(pad_out8), m_reg[0]);
         check("rnd_pad_oe", 32'(pad_oe8), m_reg[1]);
         check("rnd_irq", 32'(irq8), 32'(|(m_reg[6] & m_reg[3])));
         check("rnd_rvalid", 32'(bus8.rvalid), 32'(m_rvalid));
         check("rnd_rdata", bus8.rdata, m_rdata);
         if (c == 300) begin
            rst = 1'b1;
            #2;
            rst = 1'b0;
         end
         bus8.we    = ($urandom_range(0, 2) == 0);
         bus8.re    = ($urandom_range(0, 1) == 0);
         bus8.addr  = 3'($urandom_range(0, 7));
         bus8.wdata = $urandom;
         if ($urandom_range(0, 3) == 0) pad8 = 8'($urandom);
         @(negedge clk);
      end
      bus8.we = 1'b0; bus8.re = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/gpio_bank.md
# gpio_bank

Parametrised memory-mapped GPIO peripheral for the RISC-V core. It replaces direct wiring of core GPIO bits to pads with a register bank that provides:
- per-pin direction and output registers;
- synchronised input sampling;
- per-pin rising/falling-edge interrupt capture with a single aggregated interrupt line.

Pad tristate buffers live in the top level and are driven from `pad_out`/`pad_oe`.

## Interface
- `WIDTH`, default 8: number of GPIO pins, 1..32.
- `RESET_OUT`, default 0: reset value of the DATA_OUT register. Only bits [WIDTH-1:0] are used.
- `clk` input 1: the single clock for the block.
- `rst` input 1: reset. Asynchronous and active-high.
- `addr` input 3: word register index.
- `wdata` input 32: write data.
- `we` input 1: write strobe, one cycle per write.
- `re` input 1: read strobe, one cycle per read.
- `rdata` output 32: read data.
- `rvalid` output 1: high for exactly one cycle when `rdata` is valid.
- `pad_in` input WIDTH: raw pad inputs, asynchronous to `clk`.
- `pad_out` output WIDTH: pad output values.
- `pad_oe` output WIDTH: pad output enables (1 = drive).
- `irq` output 1: level interrupt, equal to |(IRQ_STATUS & IRQ_EN).

## Operation
Register map (`addr`):
- 0 DATA_OUT (RW): drives `pad_out`.
- 1 DIR (RW): drives `pad_oe`.
- 2 DATA_IN (RO): synchronised pin values.
- 3 IRQ_EN (RW): per-pin interrupt enable.
- 4 IRQ_RISE (RW): capture rising edges.
- 5 IRQ_FALL (RW): capture falling edges.
- 6 IRQ_STATUS (R/W1C): write 1 to clear a bit; writing 0 leaves the bit unchanged.
- 7: reserved; reads 0, writes ignored.

Register behaviour:
- All registers are WIDTH bits wide. Bits [31:WIDTH] read as 0 and are ignored on write.
- Writes to DATA_IN are ignored.
- DATA_IN reflects pin state regardless of DIR. An output pin reads back its own driven value through the pad loop.

Input path and edge capture:
- Each `pad_in` bit passes through a two-flop synchroniser (`s1`, `s2`). A third register `prev` holds the previous `s2`.
- Rising-edge event on bit i: `s2[i]=1 && prev[i]=0 && IRQ_RISE[i]`.
- Falling-edge event on bit i: `s2[i]=0 && prev[i]=1 && IRQ_FALL[i]`.
- An event sets IRQ_STATUS[i]. Status bits are sticky until cleared by W1C.
- Edge capture is independent of IRQ_EN. IRQ_EN only masks `irq`.

Simultaneous events and strobes:
- If an edge event and a W1C on the same bit occur in the same cycle, the set wins and the bit stays 1.
- `we` and `re` in the same cycle are both honoured. Read data is the pre-write register value.
- A read of IRQ_STATUS does not clear it.

Reset (`rst` high, asynchronous):
- DATA_OUT = RESET_OUT.
- DIR, IRQ_EN, IRQ_RISE, IRQ_FALL and IRQ_STATUS = 0.
- `s1`, `s2`, `prev` = 0.
- `rdata` = 0, `rvalid` = 0, `irq` = 0.
- Consequently `pad_oe` = 0 (all inputs) and `pad_out` = RESET_OUT.
- A read in flight when reset asserts is dropped: no `rvalid` follows.
- Edge detection is armed from reset state, so a pin that is high at reset release produces one rising event once IRQ_RISE is set, but only if the rising transition of `s2` occurs after IRQ_RISE is set.

## Timing
- Write accepted at clock edge N. The new register value, and therefore `pad_out`/`pad_oe`, is visible after edge N.
- Read: `re` at edge N, then `rdata`/`rvalid` are registered and valid during cycle N+1. `rdata` holds its value until the next read; `rvalid` is a one-cycle pulse.
- Back-to-back reads every cycle are supported, giving one `rvalid` per cycle.
- Input latency: a `pad_in` change that meets setup before edge K appears in `s2`/DATA_IN after edge K+1.
- Status latency: the corresponding IRQ_STATUS bit sets after edge K+2. `irq` is combinational from registers and rises in the same cycle as the status bit.
- W1C at edge N: status clears and `irq` falls after edge N, unless an event sets the bit at the same edge.
- Minimum pulse width for guaranteed capture is 2 `clk` periods. Shorter pulses may be missed.

## Test plan
- Reset values: assert `rst` mid-read with WIDTH=8, RESET_OUT=8'hA5 -> `pad_out`=8'hA5, `pad_oe`=0, `irq`=0, and no `rvalid` after release. Reads of addr 0..7 return 8'hA5, 0, pad value, 0, 0, 0, 0, 0.
- Register access: write DIR=32'hFFFF_FF0F -> `pad_oe`=8'h0F on the next cycle and readback 32'h0000_000F. A write of 8'hFF to DATA_IN is ignored. Read with `re` at edge N -> `rvalid` only in cycle N+1.
- Rising capture: IRQ_RISE=8'h01, IRQ_EN=8'h01, then `pad_in[0]` goes 0->1 before edge K -> IRQ_STATUS=8'h01 and `irq`=1 after edge K+2. Write IRQ_STATUS=8'h01 -> `irq`=0 next cycle.
- Falling capture with mask: IRQ_FALL=8'h80, IRQ_EN=0, then `pad_in[7]` goes 1->0 -> status bit 7 is set and `irq` stays 0. Set IRQ_EN=8'h80 -> `irq`=1 next cycle.
- Simultaneous set and clear: W1C of bit 2 issued at the same edge that a bit-2 rising event lands -> bit 2 remains 1 and `irq` stays high.
- Parameter sweep: WIDTH=1 and WIDTH=32 pass all of the above. For WIDTH=1, bits [31:1] of every readback are 0.
